// File: rtl/snax_alu_pkg.sv
// rtl/snax_alu_pkg.sv - shared op encoding and default sizing for the SNAX ALU datapath
//
// Contents:
//   alu_op_e          2-bit op select driven by the ALU CSR block
//   NumPEDefault      default lane count
//   DataWidthDefault  default operand width per lane
//   FifoDepthDefault  default output FIFO depth
package snax_alu_pkg;

    localparam int unsigned NumPEDefault     = 4;
    localparam int unsigned DataWidthDefault = 64;
    localparam int unsigned FifoDepthDefault = 2;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_MUL = 2'd2,
        ALU_XOR = 2'd3
    } alu_op_e;

endpackage

// File: rtl/snax_alu_fifo.sv
// rtl/snax_alu_fifo.sv - generic synchronous FIFO with pointer/count bookkeeping
//
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset (clears pointers and count)
//   push_i, data_i  write request and data (ignored while full)
//   pop_i           read request (ignored while empty)
//   data_o          head entry, stable until popped
//   full_o, empty_o occupancy flags
// Depth must be a power of two (>= 2) so the pointers wrap naturally.
module snax_alu_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [PtrW-1:0]  wptr;
    logic [PtrW-1:0]  rptr;
    logic [CntW-1:0]  count;
    logic [Width-1:0] mem [Depth];
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count == CntW'(Depth));
    assign empty_o = (count == '0);
    assign data_o  = mem[rptr];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PtrW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; only entries behind a valid pointer are ever read.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wptr] <= data_i;
        end
    end

endmodule

// File: rtl/snax_alu_datapath.sv
// rtl/snax_alu_datapath.sv - SNAX ALU streaming compute stage: A/B join, lane ALU, output FIFO
//
// Ports:
//   clk_i, rst_ni                  clock, synchronous active-low reset
//   alu_config_i                   op select (add/sub/mul/xor), sampled per fired beat
//   acc_ready_i                    job active; gates acceptance of new beats
//   a_i/a_valid_i/a_ready_o        operand A stream, lane k at [k*DataWidth +: DataWidth]
//   b_i/b_valid_i/b_ready_o        operand B stream, same packing
//   c_o/c_valid_o/c_ready_i        result stream, lane k at [k*2*DataWidth +: 2*DataWidth]
//   acc_output_success_o           one pulse per result handshake
//   beat_count_o                   fired-beat counter (only with SNAX_ALU_DATAPATH_BEAT_CNT_EN)
module snax_alu_datapath
    import snax_alu_pkg::*;
#(
    parameter int unsigned NumPE     = NumPEDefault,
    parameter int unsigned DataWidth = DataWidthDefault,
    parameter int unsigned FifoDepth = FifoDepthDefault
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [1:0]                   alu_config_i,
    input  logic                         acc_ready_i,
    input  logic [NumPE*DataWidth-1:0]   a_i,
    input  logic                         a_valid_i,
    output logic                         a_ready_o,
    input  logic [NumPE*DataWidth-1:0]   b_i,
    input  logic                         b_valid_i,
    output logic                         b_ready_o,
    output logic [NumPE*2*DataWidth-1:0] c_o,
    output logic                         c_valid_o,
    input  logic                         c_ready_i,
    output logic                         acc_output_success_o
`ifdef SNAX_ALU_DATAPATH_BEAT_CNT_EN
    ,
    output logic [31:0]                  beat_count_o
`endif
);

    localparam int unsigned CW = 2 * DataWidth;

    logic                  full;
    logic                  empty;
    logic                  can_accept;
    logic                  fire;
    logic                  pop;
    alu_op_e               op;
    logic [NumPE*CW-1:0]   result;

    // Readiness deliberately ignores c_ready_i: a full FIFO blocks input even
    // in a cycle where it also pops, keeping the output side off the input path.
    assign can_accept = acc_ready_i & ~full;
    assign a_ready_o  = b_valid_i & can_accept;
    assign b_ready_o  = a_valid_i & can_accept;
    assign fire       = a_valid_i & b_valid_i & can_accept;

    assign op = alu_op_e'(alu_config_i);

    for (genvar k = 0; k < NumPE; k++) begin : g_lane
        logic [CW-1:0] a_ext;
        logic [CW-1:0] b_ext;
        logic [CW-1:0] lane_c;

        assign a_ext = CW'(a_i[k*DataWidth +: DataWidth]);
        assign b_ext = CW'(b_i[k*DataWidth +: DataWidth]);

        // Operands are zero-extended, so the product of two DataWidth values
        // fits exactly in CW bits and sub wraps modulo 2^CW.
        always_comb begin
            lane_c = a_ext ^ b_ext;
            case (op)
                ALU_ADD: lane_c = a_ext + b_ext;
                ALU_SUB: lane_c = a_ext - b_ext;
                ALU_MUL: lane_c = a_ext * b_ext;
                default: lane_c = a_ext ^ b_ext;
            endcase
        end

        assign result[k*CW +: CW] = lane_c;
    end

    assign c_valid_o            = ~empty;
    assign pop                  = c_valid_o & c_ready_i;
    assign acc_output_success_o = pop;

    snax_alu_fifo #(
        .Width (NumPE * CW),
        .Depth (FifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fire),
        .data_i  (result),
        .pop_i   (pop),
        .data_o  (c_o),
        .full_o  (full),
        .empty_o (empty)
    );

`ifdef SNAX_ALU_DATAPATH_BEAT_CNT_EN
    logic acc_ready_q;

    // A job start (acc_ready_i rising) restarts the count; a beat fired in
    // that same cycle belongs to the new job and is counted.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_ready_q  <= 1'b0;
            beat_count_o <= '0;
        end else begin
            acc_ready_q <= acc_ready_i;
            if (acc_ready_i & ~acc_ready_q) begin
                beat_count_o <= {31'd0, fire};
            end else if (fire) begin
                beat_count_o <= beat_count_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_snax_alu_datapath.sv
// tb/tb_snax_alu_datapath.sv - randomized and directed self-checking bench for snax_alu_datapath
module tb_snax_alu_datapath;

    localparam int NPE = 4;
    localparam int DW  = 64;
    localparam int DEPTH = 2;

    logic           clk_i;
    logic           rst_ni;
    logic [1:0]     alu_config_i;
    logic           acc_ready_i;
    logic [255:0]   a_i;
    logic           a_valid_i;
    logic           a_ready_o;
    logic [255:0]   b_i;
    logic           b_valid_i;
    logic           b_ready_o;
    logic [511:0]   c_o;
    logic           c_valid_o;
    logic           c_ready_i;
    logic           acc_output_success_o;
`ifdef SNAX_ALU_DATAPATH_BEAT_CNT_EN
    logic [31:0]    beat_count_o;
`endif

    snax_alu_datapath #(
        .NumPE     (NPE),
        .DataWidth (DW),
        .FifoDepth (DEPTH)
    ) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .alu_config_i         (alu_config_i),
        .acc_ready_i          (acc_ready_i),
        .a_i                  (a_i),
        .a_valid_i            (a_valid_i),
        .a_ready_o            (a_ready_o),
        .b_i                  (b_i),
        .b_valid_i            (b_valid_i),
        .b_ready_o            (b_ready_o),
        .c_o                  (c_o),
        .c_valid_o            (c_valid_o),
        .c_ready_i            (c_ready_i),
        .acc_output_success_o (acc_output_success_o)
`ifdef SNAX_ALU_DATAPATH_BEAT_CNT_EN
        ,
        .beat_count_o         (beat_count_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference state: the in-order list of results waiting downstream.
    logic [511:0] exp_q[$];
    int unsigned  model_cnt = 0;
    logic         model_prev_acc = 1'b0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] model_result(input logic [1:0] cfg,
                                                  input logic [255:0] a,
                                                  input logic [255:0] b);
        logic [511:0] r;
        logic [127:0] x, y, z;
        r = '0;
        for (int k = 0; k < NPE; k++) begin
            x = {64'd0, a[k*DW +: DW]};
            y = {64'd0, b[k*DW +: DW]};
            case (cfg)
                2'd0:    z = x + y;
                2'd1:    z = x - y;
                2'd2:    z = x * y;
                default: z = x ^ y;
            endcase
            r[k*128 +: 128] = z;
        end
        return r;
    endfunction

    function automatic logic [255:0] rand_vec();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One clock cycle: drive inputs at the falling edge, sample 1ns later,
    // then advance the reference across the rising edge.
    task automatic step(input logic rst, input logic acc, input logic av, input logic bv,
                        input logic cr, input logic [1:0] cfg,
                        input logic [255:0] a, input logic [255:0] b, input bit do_chk);
        bit full, cv, fire, pop;
        rst_ni = rst; acc_ready_i = acc; a_valid_i = av; b_valid_i = bv;
        c_ready_i = cr; alu_config_i = cfg; a_i = a; b_i = b;
        #1;
        full = (exp_q.size() == DEPTH);
        cv   = (exp_q.size() != 0);
        fire = av & bv & acc & !full;
        pop  = cv & cr;
        if (do_chk) begin
            check("a_ready", a_ready_o, bv & acc & !full);
            check("b_ready", b_ready_o, av & acc & !full);
            check("c_valid", c_valid_o, cv);
            check("success", acc_output_success_o, pop);
            if (cv) check("c_data", c_o, exp_q[0]);
`ifdef SNAX_ALU_DATAPATH_BEAT_CNT_EN
            check("beat_count", beat_count_o, model_cnt);
`endif
        end
        @(posedge clk_i);
        if (!rst) begin
            exp_q.delete();
            model_cnt = 0;
            model_prev_acc = 1'b0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (fire) exp_q.push_back(model_result(cfg, a, b));
            if (acc && !model_prev_acc) model_cnt = fire ? 1 : 0;
            else if (fire) model_cnt = model_cnt + 1;
            model_prev_acc = acc;
        end
        @(negedge clk_i);
    endtask

    initial begin
        logic [255:0] z, ones;
        z = '0;
        ones = {4{64'hFFFF_FFFF_FFFF_FFFF}};

        // reset: first cycle state unknown, second cycle checks reset values
        step(0, 1, 1, 1, 0, 0, z, z, 0);
        step(0, 1, 1, 1, 0, 0, z, z, 1);
        step(0, 0, 0, 0, 0, 0, z, z, 1);

        // add 5+7, then observe
        step(1, 1, 1, 1, 1, 0, {4{64'd5}}, {4{64'd7}}, 1);
        step(1, 1, 0, 0, 1, 0, z, z, 1);
        // sub wrap and full-width multiply
        step(1, 1, 1, 1, 1, 1, {4{64'd1}}, {4{64'd2}}, 1);
        step(1, 1, 1, 1, 1, 2, ones, ones, 1);
        step(1, 1, 0, 0, 1, 0, z, z, 1);

        // backpressure: three beats offered, two accepted, then drain
        for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 0, 2'(i), rand_vec(), rand_vec(), 1);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 1, 0, z, z, 1);

        // join: A alone for two cycles, then B joins
        for (int i = 0; i < 2; i++) step(1, 1, 1, 0, 1, 0, {4{64'd9}}, z, 1);
        step(1, 1, 1, 1, 1, 0, {4{64'd9}}, {4{64'd1}}, 1);
        step(1, 1, 0, 0, 1, 0, z, z, 1);

        // gating: job inactive blocks fires
        for (int i = 0; i < 2; i++) step(1, 0, 1, 1, 1, 0, rand_vec(), rand_vec(), 1);

        // reset with two entries queued
        for (int i = 0; i < 2; i++) step(1, 1, 1, 1, 0, 0, rand_vec(), rand_vec(), 1);
        step(0, 1, 0, 0, 0, 0, z, z, 1);
        for (int i = 0; i < 2; i++) step(1, 1, 0, 0, 1, 0, z, z, 1);

        // config applies per beat
        step(1, 0, 0, 0, 1, 0, z, z, 1);
        step(1, 1, 1, 1, 1, 0, {4{64'd6}}, {4{64'd3}}, 1);
        step(1, 1, 1, 1, 1, 3, {4{64'd6}}, {4{64'd3}}, 1);
        step(1, 1, 0, 0, 1, 0, z, z, 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)),
                 rand_vec(), rand_vec(), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
